udma_hyper_cfg_arbiter: RTL and testbench



---
 rtl/hyper_pkg.sv | 16 +
 rtl/hyper_arb_timeout_cnt.sv | 42 ++++
 rtl/udma_hyper_cfg_arbiter.sv | 147 ++++++++++++++
 tb/tb_udma_hyper_cfg_arbiter.sv | 342 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hyper_pkg.sv
// Shared types and constants for the HyperBus config-port arbiter.
package hyper_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    OWNED    = 2'd1,
    WAIT_EOT = 2'd2
  } hyper_arb_state_e;

  localparam logic [4:0] HYPER_TRIG_ADDR = 5'h0A;

  function automatic int unsigned hyper_max(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/hyper_arb_timeout_cnt.sv
// Loadable saturating cycle counter; hit_o flags the cycle whose count reaches limit_i.
module hyper_arb_timeout_cnt #(
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [CNT_W-1:0] load_val_i,
  input  logic [CNT_W-1:0] limit_i,
  output logic             hit_o
);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_inc;

  assign cnt_inc = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (load_i) begin
      cnt_d = load_val_i;
    end else if (en_i && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_inc[CNT_W-1:0];
    end
  end

  // Hit is raised one cycle early so the registered pulse lands exactly on the limit.
  assign hit_o = en_i && (cnt_inc >= {1'b0, limit_i});

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/udma_hyper_cfg_arbiter.sv
// Locks the HyperBus uDMA config port to one of two requesters until its transfer
// ends (or times out) and routes the end-of-transfer event back to that owner only.
module udma_hyper_cfg_arbiter
  import hyper_pkg::*;
#(
  parameter logic [4:0]  TRIG_ADDR = HYPER_TRIG_ADDR,
  parameter int unsigned IDLE_TO   = 1024,
  parameter int unsigned EOT_TO    = 65536
) (
  input  logic             sys_clk_i,
  input  logic             rstn_i,
  input  logic [1:0]       req_valid_i,
  input  logic [1:0][4:0]  req_addr_i,
  input  logic [1:0][31:0] req_data_i,
  input  logic [1:0]       req_rwn_i,
  output logic [1:0]       req_ready_o,
  output logic [1:0][31:0] req_data_o,
  output logic [1:0]       req_eot_o,
  output logic [1:0]       req_err_o,
  output logic             cfg_valid_o,
  output logic [4:0]       cfg_addr_o,
  output logic [31:0]      cfg_data_o,
  output logic             cfg_rwn_o,
  input  logic             cfg_ready_i,
  input  logic [31:0]      cfg_data_i,
  input  logic             evt_eot_i,
  output logic [1:0]       owner_o
);

  localparam int unsigned      CNT_W    = $clog2(hyper_max(IDLE_TO, EOT_TO)) + 1;
  localparam logic [CNT_W-1:0] IDLE_LIM = CNT_W'(IDLE_TO);
  localparam logic [CNT_W-1:0] EOT_LIM  = CNT_W'(EOT_TO);

  hyper_arb_state_e state_q, state_d;
  logic             owner_q, owner_d;
  logic             last_q, last_d;
  logic [1:0]       eot_q, eot_d;
  logic [1:0]       err_q, err_d;

  logic             cnt_clr, cnt_en, cnt_hit;
  logic [CNT_W-1:0] cnt_limit;
  logic [1:0]       owner_mask;
  logic             hs, trig;

  assign owner_mask = owner_q ? 2'b10 : 2'b01;
  assign hs   = (state_q == OWNED) && req_valid_i[owner_q] && cfg_ready_i;
  assign trig = hs && !req_rwn_i[owner_q] && (req_addr_i[owner_q] == TRIG_ADDR);

  hyper_arb_timeout_cnt #(
    .CNT_W(CNT_W)
  ) u_timeout_cnt (
    .clk_i     (sys_clk_i),
    .rstn_i    (rstn_i),
    .clr_i     (cnt_clr),
    .en_i      (cnt_en),
    .load_i    (1'b0),
    .load_val_i({CNT_W{1'b0}}),
    .limit_i   (cnt_limit),
    .hit_o     (cnt_hit)
  );

  always_ff @(posedge sys_clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= IDLE;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      eot_q   <= 2'b00;
      err_q   <= 2'b00;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      eot_q   <= eot_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    last_d    = last_q;
    eot_d     = 2'b00;
    err_d     = 2'b00;
    cnt_clr   = 1'b0;
    cnt_en    = 1'b0;
    cnt_limit = IDLE_LIM;
    unique case (state_q)
      IDLE: begin
        cnt_clr = 1'b1;
        if (|req_valid_i) begin
          // On a tie the requester that did not own the port last time wins.
          owner_d = (&req_valid_i) ? ~last_q : ~req_valid_i[0];
          state_d = OWNED;
        end
      end
      OWNED: begin
        if (hs) begin
          cnt_clr = 1'b1;
          if (trig) state_d = WAIT_EOT;
        end else begin
          cnt_en = 1'b1;
          if (cnt_hit) begin
            err_d   = owner_mask;
            last_d  = owner_q;
            state_d = IDLE;
          end
        end
      end
      WAIT_EOT: begin
        cnt_en    = 1'b1;
        cnt_limit = EOT_LIM;
        if (evt_eot_i) begin
          eot_d   = owner_mask;
          last_d  = owner_q;
          state_d = IDLE;
        end else if (cnt_hit) begin
          err_d   = owner_mask;
          last_d  = owner_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    req_ready_o = 2'b00;
    req_data_o  = '0;
    cfg_valid_o = 1'b0;
    cfg_addr_o  = 5'd0;
    cfg_data_o  = 32'd0;
    cfg_rwn_o   = 1'b1;
    owner_o     = (state_q == IDLE) ? 2'b00 : owner_mask;
    if (state_q == OWNED) begin
      cfg_valid_o          = req_valid_i[owner_q];
      cfg_addr_o           = req_addr_i[owner_q];
      cfg_data_o           = req_data_i[owner_q];
      cfg_rwn_o            = req_rwn_i[owner_q];
      req_ready_o[owner_q] = cfg_ready_i;
      req_data_o[owner_q]  = cfg_data_i;
    end
  end

  assign req_eot_o = eot_q;
  assign req_err_o = err_q;

endmodule

// File: tb/tb_udma_hyper_cfg_arbiter.sv
// Bench for udma_hyper_cfg_arbiter: directed scenarios plus random traffic,
// all outputs compared every cycle against a deadline-based ownership model.
module tb_udma_hyper_cfg_arbiter;

  localparam int         IDLE_TO = 32;
  localparam int         EOT_TO  = 64;
  localparam logic [4:0] TRIG    = 5'h0A;

  logic             clk = 1'b0;
  logic             rstn = 1'b0;
  logic [1:0]       req_valid = 2'b00;
  logic [1:0][4:0]  req_addr = '0;
  logic [1:0][31:0] req_wdata = '0;
  logic [1:0]       req_rwn = 2'b11;
  logic [1:0]       req_ready;
  logic [1:0][31:0] req_rdata;
  logic [1:0]       req_eot, req_err;
  logic             cfg_valid, cfg_rwn;
  logic [4:0]       cfg_addr;
  logic [31:0]      cfg_wdata;
  logic             cfg_ready = 1'b1;
  logic [31:0]      cfg_rdata = 32'd0;
  logic             evt = 1'b0;
  logic [1:0]       owner;

  always #5 clk = ~clk;

  udma_hyper_cfg_arbiter #(
    .TRIG_ADDR(TRIG),
    .IDLE_TO  (IDLE_TO),
    .EOT_TO   (EOT_TO)
  ) dut (
    .sys_clk_i  (clk),
    .rstn_i     (rstn),
    .req_valid_i(req_valid),
    .req_addr_i (req_addr),
    .req_data_i (req_wdata),
    .req_rwn_i  (req_rwn),
    .req_ready_o(req_ready),
    .req_data_o (req_rdata),
    .req_eot_o  (req_eot),
    .req_err_o  (req_err),
    .cfg_valid_o(cfg_valid),
    .cfg_addr_o (cfg_addr),
    .cfg_data_o (cfg_wdata),
    .cfg_rwn_o  (cfg_rwn),
    .cfg_ready_i(cfg_ready),
    .cfg_data_i (cfg_rdata),
    .evt_eot_i  (evt),
    .owner_o    (owner)
  );

  int checks   = 0;
  int failures = 0;
  int eot_cnt[2];

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model: who owns the port, whether a transfer is in flight, and the
  // absolute clock edge at which the current owner gets revoked.
  int         m_owner = -1;
  bit         m_wait = 1'b0;
  int         m_last = 1;
  longint     m_edge = 0;
  longint     m_deadline = 0;
  logic [1:0] m_eot = 2'b00;
  logic [1:0] m_err = 2'b00;

  task automatic model_step();
    if (!rstn) begin
      m_owner = -1; m_wait = 1'b0; m_last = 1;
      m_eot = 2'b00; m_err = 2'b00; m_edge = 0; m_deadline = 0;
    end else begin
      m_edge++;
      m_eot = 2'b00;
      m_err = 2'b00;
      if (m_owner < 0) begin
        if (req_valid != 2'b00) begin
          m_owner    = (req_valid == 2'b11) ? (1 - m_last) : (req_valid[0] ? 0 : 1);
          m_deadline = m_edge + IDLE_TO;
        end
      end else if (!m_wait) begin
        if (req_valid[m_owner] && cfg_ready) begin
          if (!req_rwn[m_owner] && req_addr[m_owner] == TRIG) begin
            m_wait     = 1'b1;
            m_deadline = m_edge + EOT_TO;
          end else begin
            m_deadline = m_edge + IDLE_TO;
          end
        end else if (m_edge == m_deadline) begin
          m_err[m_owner] = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
        end
      end else begin
        if (evt) begin
          m_eot[m_owner] = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
          m_wait  = 1'b0;
        end else if (m_edge == m_deadline) begin
          m_err[m_owner] = 1'b1;
          m_last  = m_owner;
          m_owner = -1;
          m_wait  = 1'b0;
        end
      end
    end
  endtask

  initial forever begin
    @(posedge clk or negedge rstn);
    model_step();
  end

  // Per-cycle comparison of every output, sampled mid-cycle.
  initial forever begin
    logic [1:0]       e_ready, e_owner;
    logic [1:0][31:0] e_rdata;
    logic [38:0]      e_cfg;
    @(negedge clk);
    e_ready = 2'b00;
    e_rdata = '0;
    e_cfg   = {1'b0, 5'd0, 32'd0, 1'b1};
    e_owner = (m_owner < 0) ? 2'b00 : ((m_owner == 0) ? 2'b01 : 2'b10);
    if (m_owner >= 0 && !m_wait) begin
      e_ready[m_owner] = cfg_ready;
      e_rdata[m_owner] = cfg_rdata;
      e_cfg = {req_valid[m_owner], req_addr[m_owner], req_wdata[m_owner], req_rwn[m_owner]};
    end
    check_eq("ready", 64'(req_ready), 64'(e_ready));
    check_eq("rdata", 64'(req_rdata), 64'(e_rdata));
    check_eq("cfg", 64'({cfg_valid, cfg_addr, cfg_wdata, cfg_rwn}), 64'(e_cfg));
    check_eq("owner", 64'(owner), 64'(e_owner));
    check_eq("eot", 64'(req_eot), 64'(m_eot));
    check_eq("err", 64'(req_err), 64'(m_err));
    eot_cnt[0] += int'(req_eot[0]);
    eot_cnt[1] += int'(req_eot[1]);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int r, input logic [4:0] a, input logic rw);
    req_valid[r] = 1'b1;
    req_addr[r]  = a;
    req_rwn[r]   = rw;
    req_wdata[r] = $urandom;
  endtask

  // Waits for requester r's handshake, then drops its valid after the accepting edge.
  task automatic wait_hs(input int r, output int lat);
    bit got = 1'b0;
    lat = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (req_valid[r] && req_ready[r]) got = 1'b1;
    end
    if (!got) check_eq("hs_timeout", 64'(0), 64'(1));
    tick();
    req_valid[r] = 1'b0;
  endtask

  // Counts edges after the current one until an err pulse is seen.
  task automatic edges_to_err(output int n);
    bit got = 1'b0;
    n = 0;
    for (int i = 0; i < EOT_TO + 20 && !got; i++) begin
      @(posedge clk);
      n++;
      @(negedge clk);
      if (req_err != 2'b00) got = 1'b1;
    end
    if (!got) check_eq("err_timeout", 64'(0), 64'(1));
  endtask

  task automatic wait_free();
    bit got = 1'b0;
    for (int i = 0; i < 400 && !got; i++) begin
      @(negedge clk);
      if (owner == 2'b00) got = 1'b1;
    end
    if (!got) check_eq("free_timeout", 64'(0), 64'(1));
    tick();
  endtask

  task automatic pulse_evt();
    evt = 1'b1;
    tick();
    evt = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, n, e1;
    logic [1:0] hs;

    // Single requester: write 1, 2, trigger, eot after 50 cycles.
    repeat (3) tick();
    rstn = 1'b1;
    set_req(0, 5'd1, 1'b0);
    wait_hs(0, lat);
    check_eq("t1_first_lat", 64'(lat), 64'(2));
    set_req(0, 5'd2, 1'b0);
    wait_hs(0, lat);
    check_eq("t1_owned_lat", 64'(lat), 64'(1));
    set_req(0, TRIG, 1'b0);
    wait_hs(0, lat);
    repeat (50) tick();
    pulse_evt();
    @(negedge clk);
    check_eq("t1_eot", 64'(req_eot), 64'(2'b01));
    check_eq("t1_owner_free", 64'(owner), 64'(2'b00));
    tick();

    // Both valid across reset release: requester 0 first, then 1.
    rstn = 1'b0;
    set_req(0, TRIG, 1'b0);
    set_req(1, 5'd5, 1'b0);
    tick();
    rstn = 1'b1;
    wait_hs(0, lat);
    @(negedge clk);
    check_eq("t2_owner0", 64'(owner), 64'(2'b01));
    check_eq("t2_r1_stalled", 64'(req_ready[1]), 64'(0));
    tick();
    repeat (5) tick();
    pulse_evt();
    @(negedge clk);
    check_eq("t2_eot0", 64'(req_eot), 64'(2'b01));
    tick();
    @(negedge clk);
    check_eq("t2_owner1", 64'(owner), 64'(2'b10));
    wait_hs(1, lat);

    // Requester 1 goes silent while requester 0 waits.
    set_req(0, 5'd3, 1'b1);
    edges_to_err(n);
    check_eq("t3_err_edges", 64'(n), 64'(IDLE_TO));
    check_eq("t3_err_val", 64'(req_err), 64'(2'b10));
    @(negedge clk);
    check_eq("t3_owner0", 64'(owner), 64'(2'b01));
    tick();
    wait_hs(0, lat);
    wait_free();

    // Trigger without eot: err after EOT_TO, late eot dropped.
    e1 = eot_cnt[0];
    set_req(0, TRIG, 1'b0);
    wait_hs(0, lat);
    edges_to_err(n);
    check_eq("t4_err_edges", 64'(n), 64'(EOT_TO));
    check_eq("t4_err_val", 64'(req_err), 64'(2'b01));
    tick();
    repeat (2) tick();
    pulse_evt();
    @(negedge clk);
    check_eq("t4_late_eot", 64'(req_eot), 64'(2'b00));
    tick();
    check_eq("t4_eot_count", 64'(eot_cnt[0] - e1), 64'(0));

    // Spurious eot in IDLE, OWNED and coincident with the trigger.
    e1 = eot_cnt[1];
    pulse_evt();
    set_req(1, 5'd1, 1'b0);
    wait_hs(1, lat);
    pulse_evt();
    evt = 1'b1;
    set_req(1, TRIG, 1'b0);
    wait_hs(1, lat);
    evt = 1'b0;
    @(negedge clk);
    check_eq("t5_still_owned", 64'(owner), 64'(2'b10));
    tick();
    repeat (10) tick();
    pulse_evt();
    @(negedge clk);
    check_eq("t5_eot", 64'(req_eot), 64'(2'b10));
    tick();
    check_eq("t5_eot_count", 64'(eot_cnt[1] - e1), 64'(1));

    // Asynchronous reset in WAIT_EOT.
    set_req(0, TRIG, 1'b0);
    wait_hs(0, lat);
    repeat (3) tick();
    cfg_ready = 1'b1;
    #2;
    rstn = 1'b0;
    #1;
    check_eq("t6_owner", 64'(owner), 64'(2'b00));
    check_eq("t6_pulses", 64'({req_eot, req_err, req_ready}), 64'(0));
    check_eq("t6_cfg", 64'({cfg_valid, cfg_addr, cfg_wdata, cfg_rwn}), 64'({1'b0, 5'd0, 32'd0, 1'b1}));
    check_eq("t6_rdata", 64'(req_rdata), 64'(0));
    set_req(0, 5'd4, 1'b0);
    set_req(1, 5'd6, 1'b0);
    tick();
    tick();
    rstn = 1'b1;
    tick();
    @(negedge clk);
    check_eq("t6_tie_owner", 64'(owner), 64'(2'b01));
    wait_hs(0, lat);
    wait_hs(1, lat);
    wait_free();

    // Random traffic; requesters hold valid until accepted.
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk);
      hs = req_valid & req_ready;
      tick();
      for (int r = 0; r < 2; r++) begin
        if (hs[r]) req_valid[r] = 1'b0;
        if (!req_valid[r] && ($urandom_range(0, (c < 1500) ? 3 : 39) == 0)) begin
          set_req(r, ($urandom_range(0, 3) == 0) ? TRIG : 5'($urandom), 1'($urandom));
        end
      end
      evt       = ($urandom_range(0, 11) == 0);
      cfg_ready = 1'($urandom);
      cfg_rdata = $urandom;
    end
    evt = 1'b0;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
